// File: rtl/hmac_seq_ctrl.sv
// hmac_seq_ctrl: single-requester sequencer in front of hmac_top.
// Enrols the PUF key, buffers message words in a FIFO, streams them to the core and returns MAC + status.
module hmac_seq_ctrl #(
  parameter int FIFO_DEPTH  = 16,
  parameter int LEN_W       = 8,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [703:0]     puf_challenge,
  input  logic             key_regen,
  input  logic             req_valid,
  input  logic [LEN_W-1:0] req_len,
  output logic             req_ready,
  input  logic [31:0]      in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_status,
  output logic [511:0]     res_mac,
  output logic             key_valid,
  output logic             busy,
  output logic             core_start_puf,
  output logic             core_start_hmac,
  output logic [703:0]     core_puf_input,
  output logic [31:0]      core_msg_word,
  output logic             core_msg_valid,
  output logic             core_msg_last,
  input  logic             core_msg_ready,
  input  logic             core_done,
  input  logic [511:0]     core_hmac_value
);
  // state     | meaning
  // IDLE      | accept a request or start a pending key regen
  // PUF_START | start_puf pulse, challenge latched
  // PUF_WAIT  | waiting for enrolment done
  // MAC_START | start_hmac pulse
  // STREAM    | FIFO words to the core
  // MAC_WAIT  | waiting for MAC done
  // RESULT    | result held until res_ready
  typedef enum logic [2:0] {
    IDLE, PUF_START, PUF_WAIT, MAC_START, STREAM, MAC_WAIT, RESULT
  } state_t;

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [19:0] TMO_LOAD = 20'(TIMEOUT_CYC - 1);
  localparam logic [1:0]  ST_OK    = 2'b00;
  localparam logic [1:0]  ST_TMO   = 2'b01;
  localparam logic [1:0]  ST_BAD   = 2'b10;

  state_t           state;
  logic [LEN_W-1:0] len, words_in, words_out;
  logic             req_pending, regen_pend, done_d, armed;
  logic [19:0]      tmo_cnt;
  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fifo_cnt;
  logic             fifo_full, fifo_empty, push, pop, done_rise, counting, tmo_fire, req_acc;

  assign fifo_full      = (fifo_cnt == FULL_CNT);
  assign fifo_empty     = (fifo_cnt == '0);
  assign req_ready      = armed && (state == IDLE) && !regen_pend && !key_regen;
  assign req_acc        = req_valid && req_ready;
  assign in_ready       = req_pending && !fifo_full && (words_in < len);
  assign push           = in_valid && in_ready;
  assign core_msg_valid = (state == STREAM) && !fifo_empty;
  assign core_msg_word  = fifo_mem[rd_ptr];
  assign core_msg_last  = (state == STREAM) && (words_out == len - LEN_W'(1));
  assign pop            = core_msg_valid && core_msg_ready;
  assign done_rise      = core_done && !done_d;
  assign busy           = (state != IDLE);
  assign counting       = state inside {PUF_WAIT, STREAM, MAC_WAIT};
  // A timeout only fires in a cycle with no core progress
  assign tmo_fire       = counting && (tmo_cnt == '0) && !done_rise && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (tmo_fire) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= in_word;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      len             <= '0;
      words_in        <= '0;
      words_out       <= '0;
      req_pending     <= 1'b0;
      regen_pend      <= 1'b0;
      done_d          <= 1'b0;
      armed           <= 1'b0;
      tmo_cnt         <= '0;
      key_valid       <= 1'b0;
      res_valid       <= 1'b0;
      res_status      <= '0;
      res_mac         <= '0;
      core_start_puf  <= 1'b0;
      core_start_hmac <= 1'b0;
      core_puf_input  <= '0;
    end else begin
      armed           <= 1'b1;
      done_d          <= core_done;
      core_start_puf  <= 1'b0;
      core_start_hmac <= 1'b0;
      if (key_regen && state != IDLE) regen_pend <= 1'b1;
      if (push) words_in <= words_in + 1'b1;
      if (pop) words_out <= words_out + 1'b1;
      // Reload on every entry to a counting state (all such entries come from a
      // non-counting state or on a core transfer) and on each transfer.
      if (!counting || pop)   tmo_cnt <= TMO_LOAD;
      else if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;

      unique case (state)
        IDLE: begin
          if (regen_pend || key_regen) begin
            state          <= PUF_START;
            regen_pend     <= 1'b0;
            core_start_puf <= 1'b1;
            core_puf_input <= puf_challenge;
            key_valid      <= 1'b0;
          end else if (req_acc) begin
            if (req_len == '0) begin
              state      <= RESULT;
              res_valid  <= 1'b1;
              res_status <= ST_BAD;
              res_mac    <= '0;
            end else begin
              len         <= req_len;
              words_in    <= '0;
              words_out   <= '0;
              req_pending <= 1'b1;
              if (!key_valid) begin
                state          <= PUF_START;
                core_start_puf <= 1'b1;
                core_puf_input <= puf_challenge;
              end else begin
                state           <= MAC_START;
                core_start_hmac <= 1'b1;
              end
            end
          end
        end
        PUF_START: state <= PUF_WAIT;
        PUF_WAIT: begin
          if (done_rise) begin
            key_valid <= 1'b1;
            if (req_pending) begin
              state           <= MAC_START;
              core_start_hmac <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        MAC_START: state <= STREAM;
        STREAM: begin
          if (pop && core_msg_last) state <= MAC_WAIT;
        end
        MAC_WAIT: begin
          if (done_rise) begin
            state       <= RESULT;
            res_valid   <= 1'b1;
            res_status  <= ST_OK;
            res_mac     <= core_hmac_value;
            req_pending <= 1'b0;
          end
        end
        RESULT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (tmo_fire) begin
        state       <= RESULT;
        res_valid   <= 1'b1;
        res_status  <= ST_TMO;
        res_mac     <= '0;
        req_pending <= 1'b0;
      end
    end
  end

endmodule
